mem_arbiter2: RTL and testbench
===============================

MEM_ARBITER2 -- requirements
Module: mem_arbiter2

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; wstrb width is DATA_W/8.
REQ-003 SHALL have parameter PRIO_MODE, default 0, where 0 is round-robin and 1 is fixed priority with m0 highest.
REQ-004 SHALL have parameter TIMEOUT, default 255, the maximum number of BUSY cycles before a forced error response; 0 disables the timeout.
REQ-005 SHALL have port clk  in  1  single clock, all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports mN_valid  in  1  master N request (N=0 instruction side, N=1 data side).
REQ-008 SHALL have ports mN_instr  in  1  master N instruction-fetch tag.
REQ-009 SHALL have ports mN_addr  in  ADDR_W  master N byte address.
REQ-010 SHALL have ports mN_wdata  in  DATA_W  master N write data.
REQ-011 SHALL have ports mN_wstrb  in  DATA_W/8  master N byte-write enables, all-zero meaning read.
REQ-012 SHALL have ports mN_ready  out  1  master N one-cycle completion pulse.
REQ-013 SHALL have ports mN_rdata  out  DATA_W  master N read data, valid while mN_ready=1.
REQ-014 SHALL have ports mN_err  out  1  master N timeout flag, qualified by mN_ready.
REQ-015 SHALL have ports s_valid, s_instr, s_addr, s_wdata, s_wstrb  out  1/1/ADDR_W/DATA_W/DATA_W/8  shared memory request.
REQ-016 SHALL have ports s_ready  in  1  and  s_rdata  in  DATA_W  shared memory completion pulse and read data.

Function
REQ-017 SHALL implement the states IDLE, BUSY0 and BUSY1 in a registered FSM.
REQ-018 In IDLE, SHALL drive s_valid=0, all mN_ready=0 and all mN_err=0, and SHALL ignore s_ready.
REQ-019 In IDLE, with exactly one mN_valid=1, SHALL go to BUSYN at the next edge.
REQ-020 In IDLE, with both valid and PRIO_MODE=1, SHALL go to BUSY0.
REQ-021 In IDLE, with both valid and PRIO_MODE=0, SHALL grant the master not served last, as recorded in register last_grant.
REQ-022 In BUSYN, SHALL drive s_valid, s_instr, s_addr, s_wdata and s_wstrb combinationally from master N, and SHALL set s_valid to mN_valid.
REQ-023 In BUSYN, SHALL drive mN_ready=s_ready and mN_rdata=s_rdata, and SHALL hold the other master's ready at 0 and its rdata at 0.
REQ-024 In BUSYN, when s_ready=1, SHALL set last_grant=N and return to IDLE at that edge, so s_valid is 0 on the following cycle.
REQ-025 Request latency SHALL be exactly 1 cycle from mN_valid rising in IDLE to s_valid=1.
REQ-026 Minimum back-to-back spacing SHALL be one IDLE cycle between transactions.
REQ-027 The grant SHALL be locked for the whole transaction; a new request from the other master SHALL never pre-empt it.
REQ-028 If the granted mN_valid falls before s_ready (an abort), SHALL return to IDLE without a ready pulse and without updating last_grant.
REQ-029 SHALL keep a 16-bit BUSY cycle counter that clears on entry to BUSY and increments each BUSY cycle with s_ready=0.
REQ-030 With TIMEOUT!=0, when the counter reaches TIMEOUT-1 and s_ready=0, SHALL pulse mN_ready=1, mN_err=1 and mN_rdata=0 for one cycle, set last_grant=N, and return to IDLE.
REQ-031 If s_ready=1 coincides with the timeout cycle, SHALL treat it as a normal completion with err=0.
REQ-032 mN_err SHALL be 0 in every cycle not covered by REQ-030.

Reset
REQ-033 On reset=1, SHALL immediately, without waiting for clk, force state=IDLE, last_grant=1 (so m0 wins first contention), counter=0, s_valid=0, all mN_ready=0 and all mN_err=0.
REQ-034 A reset during BUSY SHALL abandon the transaction with no ready pulse, and SHALL arbitrate normally from the first edge after reset falls.

Verification
REQ-035 Bench SHALL cover: m0 read of 0x10, slave answers 2 cycles after s_valid with 0xDEADBEEF -> s_valid rises 1 cycle after m0_valid, m0_ready pulses 1 cycle with m0_rdata=0xDEADBEEF, m1_ready stays 0.
REQ-036 Bench SHALL cover: PRIO_MODE=0, both masters requesting continuously after reset -> grant sequence m0, m1, m0, m1, separated by one IDLE cycle each.
REQ-037 Bench SHALL cover: PRIO_MODE=1, both masters requesting continuously -> m0 served 4 times in a row and m1 never granted.
REQ-038 Bench SHALL cover: TIMEOUT=8, m1 write addr 0x3FC with wstrb=4'b0011 and s_ready held 0 -> s_wstrb=0011, and m1_ready=m1_err=1 on the 8th BUSY cycle, then IDLE.
REQ-039 Bench SHALL cover: reset asserted in BUSY1 between clock edges -> s_valid drops at once with no m1_ready, then with both requesting after release m0 is granted first.
REQ-040 Bench SHALL cover: m0_valid dropped in BUSY0 before s_ready -> IDLE next cycle, no m0_ready, last_grant unchanged.

Source files
------------

// File: rtl/mem_arbiter2.sv
// Two-master to one-slave memory arbiter.
// Master 0 is the instruction side and master 1 the data side. A grant is
// held until the slave completes, the master aborts, or the BUSY timeout
// forces an error response.
module mem_arbiter2 #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  input  logic                m0_instr,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_valid,
  input  logic                m1_instr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic                s_valid,
  output logic                s_instr,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata
);

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic [15:0] r_cnt;

  logic w_busy;
  logic w_sel0;
  logic w_sel1;
  logic w_gvalid;
  logic w_abort;
  logic w_done;
  logic w_timeout;
  logic w_resp;

  // Ownership and termination conditions of the current transaction.
  // An abort (granted valid dropped) takes precedence over any response.
  assign w_busy    = (r_state == BUSY0) || (r_state == BUSY1);
  assign w_sel0    = (r_state == BUSY0);
  assign w_sel1    = (r_state == BUSY1);
  assign w_gvalid  = w_sel1 ? m1_valid : (w_sel0 & m0_valid);
  assign w_abort   = w_busy & ~w_gvalid;
  assign w_done    = w_busy & w_gvalid & s_ready;
  assign w_timeout = TO_EN & w_busy & w_gvalid & ~s_ready & (r_cnt == TO_LAST);
  assign w_resp    = w_done | w_timeout;

  // Slave request is a combinational copy of the owning master; zero in IDLE.
  assign s_valid = w_busy & w_gvalid;
  assign s_instr = w_sel1 ? m1_instr : (w_sel0 & m0_instr);
  assign s_addr  = w_sel1 ? m1_addr  : (w_sel0 ? m0_addr  : '0);
  assign s_wdata = w_sel1 ? m1_wdata : (w_sel0 ? m0_wdata : '0);
  assign s_wstrb = w_sel1 ? m1_wstrb : (w_sel0 ? m0_wstrb : '0);

  // Responses go only to the owner; read data is forced to zero on timeout.
  assign m0_ready = w_sel0 & w_resp;
  assign m0_err   = w_sel0 & w_timeout;
  assign m0_rdata = (w_sel0 && !w_timeout) ? s_rdata : '0;
  assign m1_ready = w_sel1 & w_resp;
  assign m1_err   = w_sel1 & w_timeout;
  assign m1_rdata = (w_sel1 && !w_timeout) ? s_rdata : '0;

  // Arbitration FSM, grant history and BUSY cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (m0_valid && m1_valid) begin
            if (PRIO_MODE == 1 || r_last_grant) begin
              r_state <= BUSY0;
            end else begin
              r_state <= BUSY1;
            end
          end else if (m0_valid) begin
            r_state <= BUSY0;
          end else if (m1_valid) begin
            r_state <= BUSY1;
          end
        end
        BUSY0, BUSY1: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else if (w_resp) begin
            r_state      <= IDLE;
            r_last_grant <= w_sel1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed and randomized checks of mem_arbiter2 in round-robin and
// fixed-priority configurations sharing one set of stimulus inputs.
module tb_mem_arbiter2;

  logic        clk;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  logic        m0_ready_a, m0_err_a, m1_ready_a, m1_err_a;
  logic [31:0] m0_rdata_a, m1_rdata_a;
  logic        s_valid_a, s_instr_a;
  logic [31:0] s_addr_a, s_wdata_a;
  logic [3:0]  s_wstrb_a;

  logic        m0_ready_b, m0_err_b, m1_ready_b, m1_err_b;
  logic [31:0] m0_rdata_b, m1_rdata_b;
  logic        s_valid_b, s_instr_b;
  logic [31:0] s_addr_b, s_wdata_b;
  logic [3:0]  s_wstrb_b;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_arbiter2 #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0), .TIMEOUT(8)) u_rr (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready_a), .m0_rdata(m0_rdata_a), .m0_err(m0_err_a),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready_a), .m1_rdata(m1_rdata_a), .m1_err(m1_err_a),
    .s_valid(s_valid_a), .s_instr(s_instr_a), .s_addr(s_addr_a), .s_wdata(s_wdata_a),
    .s_wstrb(s_wstrb_a), .s_ready(s_ready), .s_rdata(s_rdata)
  );

  mem_arbiter2 #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1), .TIMEOUT(8)) u_fp (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready_b), .m0_rdata(m0_rdata_b), .m0_err(m0_err_b),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready_b), .m1_rdata(m1_rdata_b), .m1_err(m1_err_b),
    .s_valid(s_valid_b), .s_instr(s_instr_b), .s_addr(s_addr_b), .s_wdata(s_wdata_b),
    .s_wstrb(s_wstrb_b), .s_ready(s_ready), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata  = '0;
  endtask

  task automatic reset_all();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Reference state for the randomized section: transaction-level model.
  int          last;
  int          g, d, kd, r;
  bit          terr, r0, r1;
  logic [31:0] a0, a1, w0, w1, rd;
  logic [3:0]  st0, st1;
  bit          in0, in1;

  initial begin
    // Reset holds everything idle even with requests and s_ready present.
    idle_inputs();
    reset = 1'b1;
    m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1;
    step();
    @(negedge clk);
    chk("rst_svalid", s_valid_a, 0);
    chk("rst_m0_ready", m0_ready_a, 0);
    chk("rst_m1_ready", m1_ready_a, 0);
    chk("rst_m0_err", m0_err_a, 0);

    // Single m0 read, slave answers two cycles after s_valid.
    reset_all();
    m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'b0000;
    @(negedge clk);
    chk("rd_idle_svalid", s_valid_a, 0);
    step();
    @(negedge clk);
    chk("rd_svalid_lat1", s_valid_a, 1);
    chk("rd_saddr", s_addr_a, 32'h10);
    chk("rd_swstrb", s_wstrb_a, 4'b0000);
    chk("rd_m0_ready_c1", m0_ready_a, 0);
    step();
    @(negedge clk);
    chk("rd_m0_ready_c2", m0_ready_a, 0);
    step();
    s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_m0_ready", m0_ready_a, 1);
    chk("rd_m0_rdata", m0_rdata_a, 32'hDEADBEEF);
    chk("rd_m0_err", m0_err_a, 0);
    chk("rd_m1_ready", m1_ready_a, 0);
    step();
    m0_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    chk("rd_after_svalid", s_valid_a, 0);
    chk("rd_after_m0_ready", m0_ready_a, 0);

    // Continuous contention: round-robin alternates, fixed priority starves m1.
    reset_all();
    m0_valid = 1'b1; m0_addr = 32'h100;
    m1_valid = 1'b1; m1_addr = 32'h200;
    s_ready = 1'b1; s_rdata = 32'h5555AAAA;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rr_svalid", s_valid_a, (c % 2 == 1));
      chk("rr_m0_ready", m0_ready_a, (c % 4 == 1));
      chk("rr_m1_ready", m1_ready_a, (c % 4 == 3));
      if (c % 2 == 1) chk("rr_saddr", s_addr_a, (c % 4 == 1) ? 32'h100 : 32'h200);
      chk("fp_m0_ready", m0_ready_b, (c % 2 == 1));
      chk("fp_m1_ready", m1_ready_b, 0);
      chk("fp_svalid", s_valid_b, (c % 2 == 1));
      step();
    end
    idle_inputs();

    // m1 write with slave silent: timeout error on the 8th BUSY cycle.
    reset_all();
    m1_valid = 1'b1; m1_addr = 32'h3FC; m1_wstrb = 4'b0011; m1_wdata = 32'hCAFE0001;
    s_rdata = 32'h12345678;
    @(negedge clk);
    chk("to_idle_svalid", s_valid_a, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      @(negedge clk);
      chk("to_svalid", s_valid_a, 1);
      chk("to_swstrb", s_wstrb_a, 4'b0011);
      chk("to_saddr", s_addr_a, 32'h3FC);
      chk("to_m1_ready", m1_ready_a, (k == 8));
      chk("to_m1_err", m1_err_a, (k == 8));
      if (k == 8) chk("to_m1_rdata", m1_rdata_a, 0);
    end
    step();
    @(negedge clk);
    chk("to_after_svalid", s_valid_a, 0);
    chk("to_after_err", m1_err_a, 0);
    idle_inputs();

    // Reset mid-cycle during BUSY1, then m0 wins the first contention.
    reset_all();
    m1_valid = 1'b1; m1_addr = 32'h200;
    step();
    @(negedge clk);
    chk("ar_busy1_svalid", s_valid_a, 1);
    #2;
    reset = 1'b1; s_ready = 1'b1;
    #1;
    chk("ar_svalid_drop", s_valid_a, 0);
    chk("ar_no_m1_ready", m1_ready_a, 0);
    step();
    m0_valid = 1'b1; m0_addr = 32'h100; s_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("ar_idle_svalid", s_valid_a, 0);
    step();
    s_ready = 1'b1;
    @(negedge clk);
    chk("ar_grant_addr", s_addr_a, 32'h100);
    chk("ar_m0_ready", m0_ready_a, 1);
    chk("ar_m1_ready", m1_ready_a, 0);
    step();
    idle_inputs();

    // m0 aborts during BUSY0: no ready, grant history unchanged.
    reset_all();
    m0_valid = 1'b1; m0_addr = 32'h100; m1_addr = 32'h200;
    step();
    @(negedge clk);
    chk("ab_svalid", s_valid_a, 1);
    step();
    m0_valid = 1'b0;
    @(negedge clk);
    chk("ab_drop_svalid", s_valid_a, 0);
    chk("ab_drop_m0_ready", m0_ready_a, 0);
    step();
    m0_valid = 1'b1; m1_valid = 1'b1;
    @(negedge clk);
    chk("ab_idle_svalid", s_valid_a, 0);
    chk("ab_idle_m0_ready", m0_ready_a, 0);
    step();
    @(negedge clk);
    chk("ab_regrant_addr", s_addr_a, 32'h100);
    step();
    s_ready = 1'b1;
    @(negedge clk);
    chk("ab_m0_ready", m0_ready_a, 1);
    step();
    idle_inputs();

    // Randomized transactions against a transaction-level model (TIMEOUT=8).
    reset_all();
    last = 1;
    for (int t = 0; t < 30; t++) begin
      r  = $urandom_range(1, 3);
      r0 = (r == 1) || (r == 3);
      r1 = (r == 2) || (r == 3);
      if (r0 && r1) g = (last == 1) ? 0 : 1;
      else          g = r1 ? 1 : 0;
      d    = $urandom_range(0, 10);
      terr = (d + 1 > 8);
      kd   = terr ? 8 : d + 1;
      a0 = $urandom; a1 = $urandom; w0 = $urandom; w1 = $urandom;
      st0 = 4'($urandom); st1 = 4'($urandom);
      in0 = 1'($urandom); in1 = 1'($urandom);
      m0_valid = r0; m0_addr = a0; m0_wdata = w0; m0_wstrb = st0; m0_instr = in0;
      m1_valid = r1; m1_addr = a1; m1_wdata = w1; m1_wstrb = st1; m1_instr = in1;
      s_ready = 1'b0;
      @(negedge clk);
      chk("rnd_idle_svalid", s_valid_a, 0);
      chk("rnd_idle_ready", {m0_ready_a, m1_ready_a}, 0);
      for (int k = 1; k <= kd; k++) begin
        step();
        rd = $urandom;
        s_ready = (k == d + 1);
        s_rdata = rd;
        @(negedge clk);
        chk("rnd_svalid", s_valid_a, 1);
        chk("rnd_saddr", s_addr_a, (g == 1) ? a1 : a0);
        chk("rnd_swdata", s_wdata_a, (g == 1) ? w1 : w0);
        chk("rnd_swstrb", s_wstrb_a, (g == 1) ? st1 : st0);
        chk("rnd_sinstr", s_instr_a, (g == 1) ? in1 : in0);
        chk("rnd_other_ready", (g == 1) ? m0_ready_a : m1_ready_a, 0);
        chk("rnd_ready", (g == 1) ? m1_ready_a : m0_ready_a, (k == kd));
        chk("rnd_err", (g == 1) ? m1_err_a : m0_err_a, (k == kd) && terr);
        if (k == kd)
          chk("rnd_rdata", (g == 1) ? m1_rdata_a : m0_rdata_a, terr ? 32'h0 : rd);
      end
      step();
      last = g;
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
